// File: rtl/encoder4to2_queue.sv
// Sequential 4-to-2 encoder: collects request pulses into a pending set and emits one
// 2-bit index per request over valid/ready. Define ROUND_ROBIN_EN for rotating selection.
module encoder4to2_queue #(
    parameter int PRIO_HIGH_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    input  logic       ready,
    output logic [1:0] out,
    output logic       valid,
    output logic [3:0] pending,
    output logic       overrun
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] out_q, out_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       handshake_s;
    logic [3:0] clr_s, rem_s;
    logic [1:0] sel_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [1:0] sel_low(input logic [3:0] req);
        logic [1:0] r;
        casez (req)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    assign handshake_s = valid_q & ready;
    assign clr_s       = handshake_s ? onehot4(out_q) : 4'b0000;
    // Bits arriving this cycle are excluded from this edge's selection.
    assign rem_s       = pending_q & ~clr_s;
    assign pending_d   = rem_s | in;
    assign overrun_d   = |(in & rem_s);

`ifdef ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;
    logic [1:0] start_s;
    logic [7:0] rot_s;

    function automatic logic [1:0] sel_rr(input logic [3:0] req, input logic [1:0] start);
        logic [7:0] dbl;
        dbl = {req, req} >> start;
        return start + sel_low(dbl[3:0]);
    endfunction

    // The handshake completing this edge already counts as the most recent grant.
    assign last_d  = handshake_s ? out_q : last_q;
    assign start_s = last_d + 2'd1;
    assign rot_s   = 8'h00;
    assign sel_s   = sel_rr(rem_s, start_s);

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 2'b11;
        end else begin
            last_q <= last_d;
        end
    end
`else
    function automatic logic [1:0] sel_high(input logic [3:0] req);
        logic [1:0] r;
        casez (req)
            4'b1???: r = 2'd3;
            4'b01??: r = 2'd2;
            4'b001?: r = 2'd1;
            4'b0001: r = 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    assign sel_s = (PRIO_HIGH_FIRST != 0) ? sel_high(rem_s) : sel_low(rem_s);
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            out_q     <= 2'b00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) state_d = HOLD;
                else                      state_d = IDLE;
            end
            HOLD: begin
                if (!ready)                  state_d = HOLD;
                else if (rem_s != 4'b0000)   state_d = HOLD;
                else                         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-value logic; a stalled code never changes
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    out_d   = sel_s;
                    valid_d = 1'b1;
                end else begin
                    out_d   = out_q;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!ready) begin
                    out_d   = out_q;
                    valid_d = 1'b1;
                end else if (rem_s != 4'b0000) begin
                    out_d   = sel_s;
                    valid_d = 1'b1;
                end else begin
                    out_d   = out_q;
                    valid_d = 1'b0;
                end
            end
            default: begin
                out_d   = out_q;
                valid_d = 1'b0;
            end
        endcase
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_encoder4to2_queue.sv
// Bench for encoder4to2_queue: two instances (low-first and high-first priority) share
// stimulus and are checked against a request-set reference model.
module tb_encoder4to2_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_s;
    logic       ready_s;
    logic [1:0] out0, out1;
    logic       valid0, valid1, ovr0, ovr1;
    logic [3:0] pend0, pend1;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    encoder4to2_queue #(.PRIO_HIGH_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .ready(ready_s),
        .out(out0), .valid(valid0), .pending(pend0), .overrun(ovr0));

    encoder4to2_queue #(.PRIO_HIGH_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .ready(ready_s),
        .out(out1), .valid(valid1), .pending(pend1), .overrun(ovr1));

    typedef struct packed {
        logic [3:0] pend;
        logic       valid;
        logic [1:0] out;
        logic       ovr;
        logic [1:0] last;
    } mstate_t;

    localparam mstate_t M_RST = '{pend: 4'b0000, valid: 1'b0, out: 2'b00, ovr: 1'b0, last: 2'b11};
    mstate_t m0, m1;

    // Reference model: one step of the request set and the presented code
    function automatic mstate_t model_next(input mstate_t s, input logic [3:0] req,
                                           input logic rdy, input bit high_first);
        mstate_t    n;
        logic [3:0] rem;
        bit         served;
        int         idx;
        n      = s;
        n.ovr  = 1'b0;
        rem    = s.pend;
        served = s.valid && rdy;
        if (served) begin
            rem[s.out] = 1'b0;
            n.last     = s.out;
        end
        for (int k = 0; k < 4; k++) if (req[k] && rem[k]) n.ovr = 1'b1;
        n.pend = rem | req;
        if (!s.valid || served) begin
            n.valid = (rem != 4'b0000);
`ifdef ROUND_ROBIN_EN
            for (int i = 4; i >= 1; i--) begin
                idx = (int'(n.last) + i) % 4;
                if (rem[idx]) n.out = 2'(idx);
            end
`else
            for (int i = 3; i >= 0; i--) begin
                idx = high_first ? 3 - i : i;
                if (rem[idx]) n.out = 2'(idx);
            end
`endif
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= M_RST;
            m1 <= M_RST;
        end else begin
            m0 <= model_next(m0, in_s, ready_s, 1'b0);
            m1 <= model_next(m1, in_s, ready_s, 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_s    = 4'b0000;
        ready_s = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_s = 4'b0000; ready_s = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({pend0, valid0, out0, ovr0} !== 8'h00) begin
            n_fail++; $display("FAIL reset_p0 got %h want 00", {pend0, valid0, out0, ovr0});
        end
        n_tests++;
        if ({pend1, valid1, out1, ovr1} !== 8'h00) begin
            n_fail++; $display("FAIL reset_p1 got %h want 00", {pend1, valid1, out1, ovr1});
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ready_s = 1'b1; in_s = 4'b0100;
        tick();
        in_s = 4'b0000;
        n_tests++;
        if ({pend0, valid0, ovr0, pend1, valid1} !== {4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0}) begin
            n_fail++; $display("FAIL single_set got %b %b %b want 0100 0 0", pend0, valid0, ovr0);
        end
        tick();
        n_tests++;
        if ({valid0, out0, pend0, valid1, out1} !== {1'b1, 2'b10, 4'b0100, 1'b1, 2'b10}) begin
            n_fail++; $display("FAIL single_present got v%b o%b p%b o1=%b want v1 o10 p0100", valid0, out0, pend0, out1);
        end
        tick();
        n_tests++;
        if ({valid0, out0, pend0, ovr0, valid1} !== {1'b0, 2'b10, 4'b0000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_done got v%b o%b p%b ov%b want v0 o10 p0000 ov0", valid0, out0, pend0, ovr0);
        end
        drain();
    endtask

    task automatic test_priority();
        logic [1:0] exp0 [3];
        logic [1:0] exp1 [3];
        exp0 = '{2'b00, 2'b01, 2'b11};
        exp1 = '{2'b11, 2'b01, 2'b00};
        ready_s = 1'b1; in_s = 4'b1011;
        tick();
        in_s = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({valid0, out0, valid1, out1} !== {1'b1, exp0[i], 1'b1, exp1[i]}) begin
                n_fail++;
                $display("FAIL prio_seq[%0d] got v%b o%b / v%b o%b want o%b / o%b", i, valid0, out0, valid1, out1, exp0[i], exp1[i]);
            end
        end
        tick();
        n_tests++;
        if ({valid0, pend0, valid1, pend1} !== 10'b0) begin
            n_fail++; $display("FAIL prio_idle got v%b p%b v%b p%b want all 0", valid0, pend0, valid1, pend1);
        end
        drain();
    endtask

    task automatic test_stall();
        ready_s = 1'b0; in_s = 4'b0011;
        tick();
        in_s = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({valid0, out0, valid1, out1} !== {1'b1, 2'b00, 1'b1, 2'b01}) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v%b o%b / v%b o%b want 1 00 / 1 01", i, valid0, out0, valid1, out1);
            end
        end
        ready_s = 1'b1;
        tick();
        n_tests++;
        if ({valid0, out0, valid1, out1} !== {1'b1, 2'b01, 1'b1, 2'b00}) begin
            n_fail++; $display("FAIL stall_next got v%b o%b / v%b o%b want 1 01 / 1 00", valid0, out0, valid1, out1);
        end
        tick();
        n_tests++;
        if ({valid0, valid1} !== 2'b00) begin
            n_fail++; $display("FAIL stall_idle got %b%b want 00", valid0, valid1);
        end
        drain();
    endtask

    task automatic test_requeue();
        ready_s = 1'b1; in_s = 4'b0010;
        tick();
        in_s = 4'b0000;
        tick();
        n_tests++;
        if ({valid0, out0} !== {1'b1, 2'b01}) begin
            n_fail++; $display("FAIL requeue_present got v%b o%b want 1 01", valid0, out0);
        end
        in_s = 4'b0010;
        tick();
        in_s = 4'b0000;
        n_tests++;
        if ({valid0, pend0, ovr0, ovr1} !== {1'b0, 4'b0010, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL requeue_set got v%b p%b ov%b want 0 0010 0", valid0, pend0, ovr0);
        end
        tick();
        n_tests++;
        if ({valid0, out0, valid1, out1} !== {1'b1, 2'b01, 1'b1, 2'b01}) begin
            n_fail++; $display("FAIL requeue_again got v%b o%b want 1 01", valid0, out0);
        end
        ready_s = 1'b0; in_s = 4'b0010;
        tick();
        in_s = 4'b0000;
        n_tests++;
        if ({ovr0, ovr1, pend0, valid0, out0} !== {1'b1, 1'b1, 4'b0010, 1'b1, 2'b01}) begin
            n_fail++; $display("FAIL overrun_pulse got ov%b%b p%b v%b o%b want ov11 p0010 v1 o01", ovr0, ovr1, pend0, valid0, out0);
        end
        tick();
        n_tests++;
        if ({ovr0, ovr1, valid0} !== 3'b001) begin
            n_fail++; $display("FAIL overrun_single got ov%b%b v%b want ov00 v1", ovr0, ovr1, valid0);
        end
        drain();
    endtask

    task automatic test_async_reset();
        ready_s = 1'b0; in_s = 4'b1110;
        tick();
        in_s = 4'b0000;
        tick();
        n_tests++;
        if ({valid0, pend0, out0, out1} !== {1'b1, 4'b1110, 2'b01, 2'b11}) begin
            n_fail++; $display("FAIL arst_setup got v%b p%b o%b o1=%b want 1 1110 01 11", valid0, pend0, out0, out1);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({pend0, valid0, out0, ovr0, pend1, valid1, out1, ovr1} !== 16'h0000) begin
            n_fail++; $display("FAIL arst_clear got p%b v%b o%b / p%b v%b o%b want all 0", pend0, valid0, out0, pend1, valid1, out1);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        ready_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({valid0, pend0, valid1, pend1} !== 10'b0) begin
                n_fail++; $display("FAIL arst_stale[%0d] got v%b p%b v%b p%b want all 0", i, valid0, pend0, valid1, pend1);
            end
        end
        drain();
    endtask

    task automatic test_round_robin();
        int served [4];
        served = '{0, 0, 0, 0};
        ready_s = 1'b1; in_s = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (valid0) served[out0]++;
            n_tests++;
            if ({pend0, valid0, out0, ovr0, pend1, valid1, out1, ovr1} !==
                {m0.pend, m0.valid, m0.out, m0.ovr, m1.pend, m1.valid, m1.out, m1.ovr}) begin
                n_fail++;
                $display("FAIL flood[%0d] got p%b v%b o%b ov%b / o%b want p%b v%b o%b ov%b / o%b", i,
                         pend0, valid0, out0, ovr0, out1, m0.pend, m0.valid, m0.out, m0.ovr, m1.out);
            end
        end
`ifdef ROUND_ROBIN_EN
        n_tests++;
        if (served[0] == 0 || served[1] == 0 || served[2] == 0 || served[3] == 0) begin
            n_fail++; $display("FAIL rr_starve got counts %0d %0d %0d %0d want all nonzero", served[0], served[1], served[2], served[3]);
        end
`else
        n_tests++;
        if (served[2] != 0 || served[3] != 0 || served[0] == 0) begin
            n_fail++; $display("FAIL fixed_flood got counts %0d %0d %0d %0d want only low indices", served[0], served[1], served[2], served[3]);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_s    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            ready_s = ($urandom_range(0, 3) != 0);
            tick();
            n_tests++;
            if ({pend0, valid0, out0, ovr0, pend1, valid1, out1, ovr1} !==
                {m0.pend, m0.valid, m0.out, m0.ovr, m1.pend, m1.valid, m1.out, m1.ovr}) begin
                n_fail++;
                $display("FAIL random[%0d] got p%b v%b o%b ov%b / p%b v%b o%b ov%b want p%b v%b o%b ov%b / p%b v%b o%b ov%b", i,
                         pend0, valid0, out0, ovr0, pend1, valid1, out1, ovr1,
                         m0.pend, m0.valid, m0.out, m0.ovr, m1.pend, m1.valid, m1.out, m1.ovr);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_stall();
        test_requeue();
        test_async_reset();
        test_round_robin();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
